cache_fill_arbiter: RTL
=======================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4, cycles from mem_en read issue to mem_rvalid.
REQ-002 Parameter BLK_WORDS, default 8, 16-bit words per cache block.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_miss  in  1  I-side block-fill request, level, held until i_done.
REQ-006 i_addr  in  16  I-side miss byte address.
REQ-007 d_miss  in  1  D-side request, level, held until d_done.
REQ-008 d_wr  in  1  qualifies d_miss: 1 = single-word write-through, 0 = block fill.
REQ-009 d_addr  in  16  D-side byte address.
REQ-010 d_wdata  in  16  D-side store data.
REQ-011 mem_en  out  1  memory access strobe, one access per cycle.
REQ-012 mem_wr  out  1  1 = write, 0 = read.
REQ-013 mem_addr  out  16  memory byte address.
REQ-014 mem_wdata  out  16  memory write data.
REQ-015 mem_rdata  in  16  read data.
REQ-016 mem_rvalid  in  1  read data valid, MEM_LAT cycles after each read issue.
REQ-017 fill_i_valid / fill_d_valid  out  1 each  fill word valid for I / D cache.
REQ-018 fill_word  out  3  word index in block of the current fill word.
REQ-019 fill_data  out  16  fill word data, equals mem_rdata.
REQ-020 i_done / d_done  out  1 each  one-cycle completion pulse.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states IDLE, FILL_I, FILL_D, WRITE; SHALL leave IDLE only on a sampled request.
REQ-023 Grant from IDLE: write (d_miss & d_wr) > fairness rule > D fill > I fill.
REQ-024 Fairness: if the previous completed grant was D-side and i_miss and d_miss are both high, I fill SHALL win; a 1-bit last_d register holds this.
REQ-025 At grant, address and write data SHALL be latched; later request-input changes SHALL be ignored until done.
REQ-026 WRITE: lasts one cycle; mem_en=1, mem_wr=1, mem_addr=latched addr, mem_wdata=latched data; d_done=1 in the same cycle; next state IDLE.
REQ-027 FILL: issue counter 0..BLK_WORDS-1; one read per cycle, mem_en=1, mem_wr=0, mem_addr={blk[15:4], issue_cnt, 1'b0}; first issue in the first FILL cycle; issues SHALL stop after word 7.
REQ-028 Return counter SHALL advance on each mem_rvalid in FILL; fill_word = return counter; fill_*_valid = mem_rvalid for the granted side only.
REQ-029 *_done SHALL pulse with the 8th fill_*_valid; state SHALL go to IDLE on the next edge; total fill occupancy = BLK_WORDS+MEM_LAT cycles.
REQ-030 Earliest next grant SHALL be in the first IDLE cycle after done, i.e. one dead cycle between services.
REQ-031 mem_rvalid in IDLE or WRITE SHALL be ignored; no fill_*_valid.
REQ-032 Dropping a request mid-service SHALL NOT abort the service.
REQ-033 Outputs SHALL be 0 when idle; mem_addr and mem_wdata SHALL be 0 when mem_en=0.

Reset
REQ-034 Reset SHALL force IDLE, clear counters and last_d, and drive all outputs to 0, including mid-fill; in-flight returns after reset SHALL be dropped per REQ-031.

Structure
REQ-035 Shared package cache_arb_pkg SHALL hold the state enum, BLK_WORDS, block-offset width (4), and default MEM_LAT.
REQ-036 One sub-module arb_fill_counter SHALL implement the issue/return counter pair with terminal flags; the FSM stays in the top module.

Verification
REQ-037 i_miss=1, i_addr=0x1236 -> reads 0x1230..0x123E on 8 consecutive cycles; fill_word 0..7 from cycle 1+MEM_LAT; i_done with word 7; busy for 12 cycles.
REQ-038 i_miss and d_miss (fill) rise together, last_d=0 -> D fill first; then I fill after one IDLE cycle.
REQ-039 D fill completes, then i_miss and d_miss both high -> I granted (fairness); d_done only after the following D fill.
REQ-040 d_miss=1, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF during an I fill -> write deferred; one-cycle write after the fill; d_done same cycle.
REQ-041 rst_n=0 at fill word 3 -> next cycle IDLE, outputs 0; trailing mem_rvalid produces no fill_*_valid; next i_miss restarts at word 0.
REQ-042 Spurious mem_rvalid in IDLE -> no valid or done output; state unchanged.

Source files
------------

// File: rtl/cache_fill_arbiter_pkg.sv
// cache_arb_pkg: shared state encoding and block geometry for the cache fill arbiter
package cache_arb_pkg;
  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} arbState_t;
  localparam int BLK_WORDS = 8;
  localparam int OFF_W = 4;
  localparam int MEM_LAT_DEF = 4;
endpackage

// File: rtl/cache_fill_arbiter_if.sv
// cache_fill_arbiter_if: request, memory and fill-return signals of the cache fill arbiter
interface cache_fill_arbiter_if;
  logic i_miss;
  logic [15:0] i_addr;
  logic d_miss;
  logic d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic mem_en;
  logic mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic mem_rvalid;
  logic fill_i_valid;
  logic fill_d_valid;
  logic [2:0] fill_word;
  logic [15:0] fill_data;
  logic i_done;
  logic d_done;
  logic busy;
  modport master (
    input i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_i_valid, fill_d_valid, fill_word, fill_data,
    output i_done, d_done, busy
  );
  modport slave (
    output i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input mem_en, mem_wr, mem_addr, mem_wdata, fill_i_valid, fill_d_valid, fill_word, fill_data,
    input i_done, d_done, busy
  );
endinterface

// File: rtl/cache_fill_arbiter_fill_counter.sv
// arb_fill_counter: per-fill issue and return word counters with terminal flags
module arb_fill_counter #(
  parameter int BLK_WORDS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic issue,
  input  logic ret,
  output logic [$clog2(BLK_WORDS)-1:0] issueIdx,
  output logic [$clog2(BLK_WORDS)-1:0] retIdx,
  output logic issueLeft,
  output logic retLast
);
  localparam int IW = $clog2(BLK_WORDS + 1);
  localparam int WW = $clog2(BLK_WORDS);
  logic [IW-1:0] issueCnt;
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      issueCnt <= '0;
      retIdx <= '0;
    end else begin
      if (issue && issueLeft) issueCnt <= issueCnt + 1'b1;
      if (ret) retIdx <= retIdx + 1'b1;
    end
  end
  assign issueIdx = issueCnt[WW-1:0];
  assign issueLeft = issueCnt < IW'(BLK_WORDS);
  assign retLast = retIdx == WW'(BLK_WORDS - 1);
endmodule

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one memory port between I-side fills and D-side fills/write-throughs
module cache_fill_arbiter #(
  parameter int MEM_LAT = cache_arb_pkg::MEM_LAT_DEF,
  parameter int BLK_WORDS = cache_arb_pkg::BLK_WORDS
) (
  input logic clk,
  input logic rst_n,
  cache_fill_arbiter_if.master bus
);
  import cache_arb_pkg::*;
  localparam int WW = $clog2(BLK_WORDS);
  // Word addressing is fixed at 16-bit words in a 16-byte block; latency must be real.
  if (MEM_LAT < 1 || BLK_WORDS != (1 << (OFF_W - 1))) begin : gBadParam
    $error("cache_fill_arbiter: unsupported MEM_LAT/BLK_WORDS");
  end
  arbState_t state, nextState;
  logic lastD;
  logic [15:0] addrQ, wdataQ;
  logic filling, issue, ret, done, issueLeft, retLast;
  logic [WW-1:0] issueIdx, retIdx;
  assign filling = state == FILL_I || state == FILL_D;
  assign issue = filling && issueLeft;
  assign ret = filling && bus.mem_rvalid;
  assign done = ret && retLast;
  arb_fill_counter #(.BLK_WORDS(BLK_WORDS)) uCnt (
    .clk(clk), .rst_n(rst_n), .clr(!filling), .issue(issue), .ret(ret),
    .issueIdx(issueIdx), .retIdx(retIdx), .issueLeft(issueLeft), .retLast(retLast)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lastD <= 1'b0;
      addrQ <= '0;
      wdataQ <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        addrQ <= nextState == FILL_I ? bus.i_addr : bus.d_addr;
        wdataQ <= bus.d_wdata;
      end
      if (state == WRITE || done) lastD <= state != FILL_I;
    end
  end
  // Grant order: write-through, then I fill when D was served last, then D fill, then I fill.
  always_comb begin
    nextState = state == IDLE ? ((bus.d_miss && bus.d_wr) ? WRITE :
                                 (bus.i_miss && (!bus.d_miss || lastD)) ? FILL_I :
                                 bus.d_miss ? FILL_D : IDLE) :
                (state == WRITE || done) ? IDLE : state;
    bus.mem_en = state == WRITE || issue;
    bus.mem_wr = state == WRITE;
    bus.mem_addr = state == WRITE ? addrQ : issue ? {addrQ[15:OFF_W], issueIdx, 1'b0} : '0;
    bus.mem_wdata = state == WRITE ? wdataQ : '0;
    bus.fill_i_valid = ret && state == FILL_I;
    bus.fill_d_valid = ret && state == FILL_D;
    bus.fill_word = ret ? retIdx : '0;
    bus.fill_data = ret ? bus.mem_rdata : '0;
    bus.i_done = done && state == FILL_I;
    bus.d_done = state == WRITE || (done && state == FILL_D);
    bus.busy = state != IDLE;
  end
endmodule
